mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester controller that shares the single main-memory port between the I-cache line-fill path and the D-cache fill/write-back path of the pipelined CPU. It arbitrates between the two requesters, sequences one fixed-latency line access at a time, and returns line data with a one-cycle done pulse. It sits between the caches, which drive the IF/MEM stall states, and the main-memory model.

## Interface
- WORD_SIZE, 16, bits per word
- LINE_WORDS, 4, words per cache line; LINE = LINE_WORDS*WORD_SIZE bits
- MEM_LATENCY, 6, memory cycles per line access; must be >= 2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  I-cache line-read request; held until i_done
- i_addr  in  WORD_SIZE  I-cache line address, stable while i_req
- i_done  out  1  one-cycle pulse: I transaction complete
- i_rdata  out  LINE  line data, valid in the i_done cycle
- d_req  in  1  D-cache request; held until d_done
- d_we  in  1  1 = line write-back, 0 = line fill
- d_addr  in  WORD_SIZE  D-cache line address
- d_wdata  in  LINE  write-back data, stable while d_req
- d_done  out  1  one-cycle pulse: D transaction complete
- d_rdata  out  LINE  fill data, valid in the d_done cycle (reads only)
- mem_read / mem_write  out  1 each  one-cycle command strobes to memory
- mem_addr  out  WORD_SIZE  latched transaction address
- mem_wdata  out  LINE  latched write data
- mem_rdata  in  LINE  memory read data
- busy  out  1  high in every state except IDLE
- owner  out  1  current or last grant: 0 = I, 1 = D
- d_conflicts  out  16  count of IDLE cycles in which both req are high; saturates at 16'hFFFF

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if neither req is high, stay. If only one is high, grant it. If both are high, grant the requester that is not `owner` (round-robin). On grant: latch owner, address, write flag, and wdata (D only), then go to ISSUE.
- ISSUE: assert mem_read or mem_write for exactly one cycle. Load the latency counter with MEM_LATENCY-2, then go to WAIT.
- WAIT: decrement the counter. When the counter is 0, capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
- RESP: pulse the owner's done, then return to IDLE.
- Requester rule: the requester drops req in the cycle after its done. A req still high in IDLE after that is treated as a new transaction.
- Write-back: timing is identical to a read. done means the write is committed, and d_rdata is not updated.
- mem_addr and mem_wdata hold their latched values until the next grant.
- Input changes during ISSUE/WAIT/RESP are ignored. The non-owner's req waits and is served next, so neither requester waits longer than one transaction.
- Reset, asynchronous and at any time, including mid-transaction: state goes to IDLE, the transaction is dropped, and requesters must reissue. Output reset values:
  - all done pulses and strobes = 0
  - busy = 0
  - owner = 0 (I), so the first contended grant goes to D
  - i_rdata, d_rdata, mem_addr, mem_wdata = 0
  - d_conflicts = 0

## Timing
- Let cycle t be the IDLE cycle in which req is sampled high.
- ISSUE is at t+1 (strobe high). WAIT occupies t+2 .. t+MEM_LATENCY. RESP/done is at t+MEM_LATENCY+1.
- Memory contract: mem_rdata is valid in the last WAIT cycle, MEM_LATENCY-1 cycles after the strobe.
- Back-to-back transactions: the earliest next grant is sampled in the IDLE cycle t+MEM_LATENCY+2, so the period is MEM_LATENCY+2 cycles.
- busy is high from t+1 through t+MEM_LATENCY+1.
- d_conflicts increments at the clock edge ending any IDLE cycle with i_req & d_req.

## Structure
- Package mem_arb_pkg contains:
  - the state enum (IDLE/ISSUE/WAIT/RESP)
  - owner encoding (OWNER_I = 0, OWNER_D = 1)
  - default parameter values
- Sub-module arb_rr2: combinational two-way round-robin picker, with inputs (req_i, req_d, last_owner) and outputs (grant_valid, grant_owner).
- Top module contains the FSM, latency counter, latches, and statistics counter.

## Test plan
- Lone I read: i_req=1, addr 16'h0040, memory returns 64'h1111_2222_3333_4444 → mem_read pulse at t+1 with mem_addr=16'h0040; i_done at t+7 with i_rdata = that value; busy for 7 cycles.
- D write-back: d_we=1, addr 16'h0080, wdata 64'hDEAD_BEEF_0000_FFFF → single mem_write pulse with matching addr/wdata; d_done at t+7; d_rdata unchanged.
- Simultaneous requests out of reset → D granted first; I granted in the IDLE cycle after d_done; d_conflicts = 1 after the first contended IDLE cycle.
- Both requesters hold requests continuously for 4 transactions → grants alternate D, I, D, I; each done arrives exactly 8 cycles after the previous one.
- Reset asserted in WAIT → all outputs are at reset values immediately, no done pulse; after release, a reissued request completes normally with the 7-cycle latency.
- MEM_LATENCY=2 instance → WAIT lasts one cycle; done arrives at t+3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int unsigned DEF_WORD_SIZE   = 16;
  localparam int unsigned DEF_LINE_WORDS  = 4;
  // Must stay >= 2: ISSUE and at least one WAIT cycle are always present.
  localparam int unsigned DEF_MEM_LATENCY = 6;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side handshakes and the main-memory port seen by mem_arbiter.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
);
  localparam int unsigned LINE = WORD_SIZE * LINE_WORDS;

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_done;
  logic [LINE-1:0]      i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [LINE-1:0]      d_wdata;
  logic                 d_done;
  logic [LINE-1:0]      d_rdata;

  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [LINE-1:0]      mem_wdata;
  logic [LINE-1:0]      mem_rdata;

  logic                 busy;
  logic                 owner;
  logic [15:0]          d_conflicts;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           busy, owner, d_conflicts
  );

  // Caches plus memory model side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           busy, owner, d_conflicts
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on contention the requester that did not own last wins.
module arb_rr2 import mem_arb_pkg::*; (
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_owner = OWNER_I;
    if (req_i && req_d) begin
      grant_owner = ~last_owner;
    end else if (req_d) begin
      grant_owner = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency main-memory port between the I-cache and D-cache line paths.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, all outputs registered.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned WORD_SIZE   = DEF_WORD_SIZE,
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned LINE = WORD_SIZE * LINE_WORDS;
  localparam int unsigned CntW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 2);

  arb_state_e           state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 owner_q;
  logic                 we_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [LINE-1:0]      wdata_q;
  logic [LINE-1:0]      i_rdata_q;
  logic [LINE-1:0]      d_rdata_q;
  logic                 i_done_q;
  logic                 d_done_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 busy_q;
  logic [15:0]          conf_q;

  logic grant_valid;
  logic grant_owner;

  arb_rr2 u_rr (
    .req_i       (bus.i_req),
    .req_d       (bus.d_req),
    .last_owner  (owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      owner_q   <= OWNER_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      conf_q    <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;

      if (state_q == StIdle && bus.i_req && bus.d_req && conf_q != 16'hFFFF) begin
        conf_q <= conf_q + 16'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            owner_q <= grant_owner;
            busy_q  <= 1'b1;
            state_q <= StIssue;
            if (grant_owner == OWNER_D) begin
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
              we_q    <= bus.d_we;
              rd_q    <= ~bus.d_we;
              wr_q    <= bus.d_we;
            end else begin
              addr_q  <= bus.i_addr;
              we_q    <= 1'b0;
              rd_q    <= 1'b1;
            end
          end
        end
        StIssue: begin
          cnt_q   <= CntLoad;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            // Memory data is valid only in this last WAIT cycle.
            if (!we_q) begin
              if (owner_q == OWNER_D) d_rdata_q <= bus.mem_rdata;
              else                    i_rdata_q <= bus.mem_rdata;
            end
            if (owner_q == OWNER_D) d_done_q <= 1'b1;
            else                    i_done_q <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.i_done      = i_done_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_done      = d_done_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.d_conflicts = conf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: latency-6 main instance plus a latency-2 instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter_if bus2 ();

  mem_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_arbiter #(.MEM_LATENCY(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [63:0] wdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic        is_d;
    logic [63:0] rdata;
  } done_t;

  cmd_t  cmd_q[$];
  cmd_t  exp_cmd_q[$];
  done_t done_q[$];
  done_t exp_done_q[$];

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int busy_cnt = 0;

  logic [63:0] mem_img [logic [15:0]];

  function automatic logic [63:0] img(input logic [15:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a, a ^ 16'hA5A5, ~a, a + 16'h0101};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic on the main instance.
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write)
      cmd_q.push_back('{cyc, bus.mem_write, bus.mem_addr, bus.mem_wdata});
    if (bus.i_done) done_q.push_back('{cyc, 1'b0, bus.i_rdata});
    if (bus.d_done) done_q.push_back('{cyc, 1'b1, bus.d_rdata});
    if (bus.busy) busy_cnt = busy_cnt + 1;
  end

  // Memory models: data valid only in the cycle LATENCY-1 after the strobe.
  int mcnt = -1;
  logic [15:0] maddr = '0;
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      mcnt  = 5;
      maddr = bus.mem_addr;
      if (bus.mem_write) mem_img[bus.mem_addr] = bus.mem_wdata;
    end else if (mcnt >= 0) begin
      mcnt = mcnt - 1;
    end
    bus.mem_rdata = (mcnt == 0) ? img(maddr) : ~img(maddr);
  end

  int mcnt2 = -1;
  logic [15:0] maddr2 = '0;
  always @(negedge clk) begin
    if (bus2.mem_read || bus2.mem_write) begin
      mcnt2  = 1;
      maddr2 = bus2.mem_addr;
    end else if (mcnt2 >= 0) begin
      mcnt2 = mcnt2 - 1;
    end
    bus2.mem_rdata = (mcnt2 == 0) ? img(maddr2) : ~img(maddr2);
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nvec++;
    if ({bus.i_done, bus.d_done, bus.mem_read, bus.mem_write, bus.busy, bus.owner} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.i_done, bus.d_done, bus.mem_read, bus.mem_write, bus.busy, bus.owner});
    end
    nvec++;
    if ({bus.i_rdata, bus.d_rdata, bus.mem_wdata, bus.mem_addr} !== '0) begin
      nfail++;
      $display("FAIL reset_data: got i=%h d=%h w=%h a=%h want 0", bus.i_rdata, bus.d_rdata,
               bus.mem_wdata, bus.mem_addr);
    end
    nvec++;
    if (bus.d_conflicts !== 16'd0) begin
      nfail++;
      $display("FAIL reset_conf: got %0d want 0", bus.d_conflicts);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lone_read();
    int t;
    bit seen = 0;
    cmd_t  ec, gc;
    done_t ed, gd;
    mem_img[16'h0040] = 64'h1111_2222_3333_4444;
    bus.i_addr = 16'h0040;
    bus.i_req  = 1'b1;
    t = cyc;
    busy_cnt = 0;
    exp_cmd_q.push_back('{t + 1, 1'b0, 16'h0040, 64'h0});
    exp_done_q.push_back('{t + 7, 1'b0, 64'h1111_2222_3333_4444});
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.i_done) begin
        bus.i_req = 1'b0;
        seen = 1;
      end
    end
    @(negedge clk);
    nvec++;
    if (!seen) begin nfail++; $display("FAIL lone_timeout: got no i_done want one"); end
    nvec++;
    if (busy_cnt != 7) begin nfail++; $display("FAIL lone_busy: got %0d want 7", busy_cnt); end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front();
      nvec++;
      if (cmd_q.size() == 0) begin
        nfail++; $display("FAIL lone_cmd: got none want cyc %0d", ec.cyc);
      end else begin
        gc = cmd_q.pop_front();
        if (gc.cyc != ec.cyc || gc.wr !== ec.wr || gc.addr !== ec.addr) begin
          nfail++;
          $display("FAIL lone_cmd: got c%0d w%b a%h want c%0d w%b a%h", gc.cyc, gc.wr, gc.addr,
                   ec.cyc, ec.wr, ec.addr);
        end
      end
    end
    while (exp_done_q.size() > 0) begin
      ed = exp_done_q.pop_front();
      nvec++;
      if (done_q.size() == 0) begin
        nfail++; $display("FAIL lone_done: got none want cyc %0d", ed.cyc);
      end else begin
        gd = done_q.pop_front();
        if (gd.cyc != ed.cyc || gd.is_d !== ed.is_d || gd.rdata !== ed.rdata) begin
          nfail++;
          $display("FAIL lone_done: got c%0d d%b %h want c%0d d%b %h", gd.cyc, gd.is_d,
                   gd.rdata, ed.cyc, ed.is_d, ed.rdata);
        end
      end
    end
    nvec++;
    if (cmd_q.size() + done_q.size() != 0) begin
      nfail++; $display("FAIL lone_extra: got %0d extra events want 0", cmd_q.size() + done_q.size());
      cmd_q.delete(); done_q.delete();
    end
  endtask

  task automatic test_write_back();
    int t;
    bit seen = 0;
    cmd_t  ec, gc;
    done_t ed, gd;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0080;
    bus.d_wdata = 64'hDEAD_BEEF_0000_FFFF;
    bus.d_req   = 1'b1;
    t = cyc;
    exp_cmd_q.push_back('{t + 1, 1'b1, 16'h0080, 64'hDEAD_BEEF_0000_FFFF});
    exp_done_q.push_back('{t + 7, 1'b1, 64'h0});
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.d_done) begin
        bus.d_req = 1'b0;
        seen = 1;
      end
    end
    @(negedge clk);
    bus.d_we = 1'b0;
    nvec++;
    if (!seen) begin nfail++; $display("FAIL wb_timeout: got no d_done want one"); end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front();
      nvec++;
      if (cmd_q.size() == 0) begin
        nfail++; $display("FAIL wb_cmd: got none want cyc %0d", ec.cyc);
      end else begin
        gc = cmd_q.pop_front();
        if (gc.cyc != ec.cyc || gc.wr !== ec.wr || gc.addr !== ec.addr || gc.wdata !== ec.wdata) begin
          nfail++;
          $display("FAIL wb_cmd: got c%0d w%b a%h %h want c%0d w%b a%h %h", gc.cyc, gc.wr,
                   gc.addr, gc.wdata, ec.cyc, ec.wr, ec.addr, ec.wdata);
        end
      end
    end
    while (exp_done_q.size() > 0) begin
      ed = exp_done_q.pop_front();
      nvec++;
      if (done_q.size() == 0) begin
        nfail++; $display("FAIL wb_done: got none want cyc %0d", ed.cyc);
      end else begin
        gd = done_q.pop_front();
        if (gd.cyc != ed.cyc || gd.is_d !== ed.is_d || gd.rdata !== ed.rdata) begin
          nfail++;
          $display("FAIL wb_done: got c%0d d%b %h want c%0d d%b %h", gd.cyc, gd.is_d, gd.rdata,
                   ed.cyc, ed.is_d, ed.rdata);
        end
      end
    end
    nvec++;
    if (cmd_q.size() != 0) begin
      nfail++; $display("FAIL wb_single_strobe: got %0d extra strobes want 0", cmd_q.size());
      cmd_q.delete();
    end
  endtask

  task automatic test_contention();
    int t;
    bit i_seen = 0, d_seen = 0;
    cmd_t  ec, gc;
    done_t ed, gd;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.i_addr = 16'h0100;
    bus.d_addr = 16'h0200;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    t = cyc;
    exp_cmd_q.push_back('{t + 1, 1'b0, 16'h0200, 64'h0});
    exp_cmd_q.push_back('{t + 9, 1'b0, 16'h0100, 64'h0});
    exp_done_q.push_back('{t + 7, 1'b1, img(16'h0200)});
    exp_done_q.push_back('{t + 15, 1'b0, img(16'h0100)});
    @(negedge clk);
    nvec++;
    if (bus.d_conflicts !== 16'd1 || bus.owner !== 1'b1) begin
      nfail++;
      $display("FAIL cont_first: got conf %0d owner %b want 1 1", bus.d_conflicts, bus.owner);
    end
    for (int k = 0; k < 40 && !(i_seen && d_seen); k++) begin
      @(negedge clk);
      if (bus.d_done) begin bus.d_req = 1'b0; d_seen = 1; end
      if (bus.i_done) begin bus.i_req = 1'b0; i_seen = 1; end
    end
    @(negedge clk);
    nvec++;
    if (!(i_seen && d_seen)) begin
      nfail++; $display("FAIL cont_timeout: got i%b d%b want both done", i_seen, d_seen);
    end
    nvec++;
    if (bus.d_conflicts !== 16'd1) begin
      nfail++; $display("FAIL cont_conf: got %0d want 1", bus.d_conflicts);
    end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front();
      nvec++;
      if (cmd_q.size() == 0) begin
        nfail++; $display("FAIL cont_cmd: got none want cyc %0d", ec.cyc);
      end else begin
        gc = cmd_q.pop_front();
        if (gc.cyc != ec.cyc || gc.wr !== ec.wr || gc.addr !== ec.addr) begin
          nfail++;
          $display("FAIL cont_cmd: got c%0d w%b a%h want c%0d w%b a%h", gc.cyc, gc.wr, gc.addr,
                   ec.cyc, ec.wr, ec.addr);
        end
      end
    end
    while (exp_done_q.size() > 0) begin
      ed = exp_done_q.pop_front();
      nvec++;
      if (done_q.size() == 0) begin
        nfail++; $display("FAIL cont_done: got none want cyc %0d", ed.cyc);
      end else begin
        gd = done_q.pop_front();
        if (gd.cyc != ed.cyc || gd.is_d !== ed.is_d || gd.rdata !== ed.rdata) begin
          nfail++;
          $display("FAIL cont_done: got c%0d d%b %h want c%0d d%b %h", gd.cyc, gd.is_d,
                   gd.rdata, ed.cyc, ed.is_d, ed.rdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int ndone = 0;
    cmd_t  ec, gc;
    done_t ed, gd;
    cmd_q.delete();
    done_q.delete();
    bus.i_addr = 16'h0400;
    bus.d_addr = 16'h0300;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    t = cyc;
    for (int n = 0; n < 4; n++) begin
      logic        isd;
      logic [15:0] a;
      isd = (n % 2 == 0);
      a   = isd ? 16'h0300 : 16'h0400;
      exp_cmd_q.push_back('{t + 1 + 8 * n, 1'b0, a, 64'h0});
      exp_done_q.push_back('{t + 7 + 8 * n, isd, img(a)});
    end
    for (int k = 0; k < 60 && ndone < 4; k++) begin
      @(negedge clk);
      if (bus.i_done || bus.d_done) ndone++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    nvec++;
    if (ndone != 4) begin nfail++; $display("FAIL b2b_timeout: got %0d dones want 4", ndone); end
    nvec++;
    if (bus.d_conflicts !== 16'd5) begin
      nfail++; $display("FAIL b2b_conf: got %0d want 5", bus.d_conflicts);
    end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front();
      nvec++;
      if (cmd_q.size() == 0) begin
        nfail++; $display("FAIL b2b_cmd: got none want cyc %0d", ec.cyc);
      end else begin
        gc = cmd_q.pop_front();
        if (gc.cyc != ec.cyc || gc.wr !== ec.wr || gc.addr !== ec.addr) begin
          nfail++;
          $display("FAIL b2b_cmd: got c%0d w%b a%h want c%0d w%b a%h", gc.cyc, gc.wr, gc.addr,
                   ec.cyc, ec.wr, ec.addr);
        end
      end
    end
    while (exp_done_q.size() > 0) begin
      ed = exp_done_q.pop_front();
      nvec++;
      if (done_q.size() == 0) begin
        nfail++; $display("FAIL b2b_done: got none want cyc %0d", ed.cyc);
      end else begin
        gd = done_q.pop_front();
        if (gd.cyc != ed.cyc || gd.is_d !== ed.is_d || gd.rdata !== ed.rdata) begin
          nfail++;
          $display("FAIL b2b_done: got c%0d d%b %h want c%0d d%b %h", gd.cyc, gd.is_d,
                   gd.rdata, ed.cyc, ed.is_d, ed.rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit seen = 0;
    done_t gd;
    bus.i_addr = 16'h0500;
    bus.i_req  = 1'b1;
    repeat (4) @(negedge clk);
    nvec++;
    if (bus.busy !== 1'b1) begin nfail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    bus.i_req = 1'b0;
    #1;
    nvec++;
    if ({bus.busy, bus.owner, bus.i_done, bus.mem_read} !== 4'b0 || bus.d_conflicts !== 16'd0) begin
      nfail++;
      $display("FAIL mid_ctrl: got busy%b own%b done%b rd%b conf%0d want all 0", bus.busy,
               bus.owner, bus.i_done, bus.mem_read, bus.d_conflicts);
    end
    nvec++;
    if ({bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      nfail++;
      $display("FAIL mid_data: got i=%h d=%h a=%h w=%h want 0", bus.i_rdata, bus.d_rdata,
               bus.mem_addr, bus.mem_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    nvec++;
    if (done_q.size() != 0) begin
      nfail++; $display("FAIL mid_nodone: got %0d dones want 0", done_q.size());
    end
    cmd_q.delete();
    done_q.delete();
    bus.i_req = 1'b1;
    t = cyc;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.i_done) begin bus.i_req = 1'b0; seen = 1; end
    end
    @(negedge clk);
    nvec++;
    if (done_q.size() == 0) begin
      nfail++; $display("FAIL mid_reissue: got no done want cyc %0d", t + 7);
    end else begin
      gd = done_q.pop_front();
      if (gd.cyc != t + 7 || gd.rdata !== img(16'h0500)) begin
        nfail++;
        $display("FAIL mid_reissue: got c%0d %h want c%0d %h", gd.cyc, gd.rdata, t + 7,
                 img(16'h0500));
      end
    end
  endtask

  task automatic test_min_latency();
    int t;
    int strobe_c = -1, done_c = -1, busy2 = 0;
    logic [63:0] rd = '0;
    bus2.i_addr = 16'h0600;
    bus2.i_req  = 1'b1;
    t = cyc;
    for (int k = 0; k < 12 && done_c < 0; k++) begin
      @(negedge clk);
      if (bus2.mem_read) strobe_c = cyc;
      if (bus2.busy) busy2++;
      if (bus2.i_done) begin
        done_c = cyc;
        rd = bus2.i_rdata;
        bus2.i_req = 1'b0;
      end
    end
    @(negedge clk);
    nvec++;
    if (strobe_c != t + 1) begin
      nfail++; $display("FAIL lat2_strobe: got cyc %0d want %0d", strobe_c, t + 1);
    end
    nvec++;
    if (done_c != t + 3) begin
      nfail++; $display("FAIL lat2_done: got cyc %0d want %0d", done_c, t + 3);
    end
    nvec++;
    if (rd !== img(16'h0600)) begin
      nfail++; $display("FAIL lat2_rdata: got %h want %h", rd, img(16'h0600));
    end
    nvec++;
    if (busy2 != 3) begin nfail++; $display("FAIL lat2_busy: got %0d want 3", busy2); end
  endtask

  initial begin
    bus.i_req = 1'b0;  bus.i_addr = '0;  bus.d_req = 1'b0;  bus.d_we = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0;
    bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    bus2.d_addr = '0;  bus2.d_wdata = '0;
    test_reset();
    test_lone_read();
    test_write_back();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_min_latency();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
